// File: rtl/instruction_decode_stage_pkg.sv
// Shared opcodes, default field widths and the decoded ID/EX entry layout.
package instruction_decode_stage_pkg;

  localparam int DEC_IW  = 20;
  localparam int DEC_OPW = 4;
  localparam int DEC_RW  = 4;

  localparam logic [DEC_OPW-1:0] OP_NOP   = 4'h0;
  localparam logic [DEC_OPW-1:0] OP_LOAD  = 4'hB;
  localparam logic [DEC_OPW-1:0] OP_STORE = 4'hC;

  typedef struct packed {
    logic [DEC_IW-1:0] instr;
    logic [DEC_RW-1:0] addr1;
    logic [DEC_RW-1:0] addr2;
    logic [DEC_RW-1:0] dest;
    logic              writesRf;
    logic              isStore;
    logic              isLoad;
  } decodeEntry_t;

endpackage

// File: rtl/instruction_decode_stage_if.sv
// IF->ID->EX handshake bundle; master is the fetch/execute side, slave is the ID stage.
interface instruction_decode_stage_if #(
  parameter int IW = 20,
  parameter int RW = 4,
  parameter int CW = 16
);
  logic          in_valid;
  logic [IW-1:0] in_instruction;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [IW-1:0] out_instruction;
  logic [RW-1:0] out_rf_addr1;
  logic [RW-1:0] out_rf_addr2;
  logic [RW-1:0] out_dest;
  logic          out_writes_rf;
  logic          out_is_store;
  logic          out_is_load;
  logic [CW-1:0] hazard_count;

  modport master (
    output in_valid, in_instruction, out_ready,
    input  in_ready, out_valid, out_instruction, out_rf_addr1, out_rf_addr2,
           out_dest, out_writes_rf, out_is_store, out_is_load, hazard_count
  );

  modport slave (
    input  in_valid, in_instruction, out_ready,
    output in_ready, out_valid, out_instruction, out_rf_addr1, out_rf_addr2,
           out_dest, out_writes_rf, out_is_store, out_is_load, hazard_count
  );
endinterface

// File: rtl/decode_fields.sv
// Pure combinational field/flag extraction for one instruction.
module decode_fields
  import instruction_decode_stage_pkg::*;
#(
  parameter int IW  = DEC_IW,
  parameter int OPW = DEC_OPW,
  parameter int RW  = DEC_RW
) (
  input  logic [IW-1:0] instr,
  output decodeEntry_t  entry,
  output logic          isNop
);
  logic [OPW-1:0] op;
  logic [RW-1:0]  f1, f2, f3;

  assign op = instr[IW-1 -: OPW];
  assign f1 = instr[IW-OPW-1 -: RW];
  assign f2 = instr[IW-OPW-RW-1 -: RW];
  assign f3 = instr[IW-OPW-2*RW-1 -: RW];

  always_comb begin
    entry         = '0;
    entry.instr   = instr;
    entry.dest    = f1;
    entry.isStore = (op == OP_STORE);
    entry.isLoad  = (op == OP_LOAD);
    isNop         = (op == OP_NOP);
    // Stores read the data register from f1; everything else reads f2/f3.
    if (entry.isStore) begin
      entry.addr1    = f1;
      entry.addr2    = f2;
      entry.writesRf = 1'b0;
    end else begin
      entry.addr1    = f2;
      entry.addr2    = f3;
      entry.writesRf = !isNop;
    end
  end
endmodule

// File: rtl/instruction_decode_stage.sv
// Registered ID stage: decode, main+skid ID/EX buffer, load-use bubble and flush.
module instruction_decode_stage
  import instruction_decode_stage_pkg::*;
#(
  parameter int IW  = DEC_IW,
  parameter int OPW = DEC_OPW,
  parameter int RW  = DEC_RW,
  parameter int CW  = 16
) (
  input logic                    clock,
  input logic                    reset,
  input logic                    flush,
  instruction_decode_stage_if.slave bus
);
  localparam logic [CW-1:0] CNT_MAX = '1;

  decodeEntry_t  dec, mainEntry, skidEntry;
  logic          decIsNop;
  logic          mainValid, skidValid;
  logic          hazard, inReady, accept, pop;
  logic [CW-1:0] hazardCount;

  decode_fields #(.IW(IW), .OPW(OPW), .RW(RW)) uDecode (
    .instr (bus.in_instruction),
    .entry (dec),
    .isNop (decIsNop)
  );

  // Only the entry at the head can be a load still ahead of the incoming instruction.
  assign hazard = mainValid && mainEntry.isLoad && bus.in_valid &&
                  ((dec.addr1 == mainEntry.dest) ||
                   (!decIsNop && (dec.addr2 == mainEntry.dest)));
  assign inReady = !skidValid && !hazard;
  assign accept  = bus.in_valid && inReady && !flush;
  assign pop     = mainValid && bus.out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      mainEntry <= '0;
      skidEntry <= '0;
    end else if (flush) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else if (pop) begin
      // A full skid forces inReady low, so accept cannot coincide with a skid refill.
      if (skidValid) begin
        mainEntry <= skidEntry;
        skidValid <= 1'b0;
      end else if (accept) begin
        mainEntry <= dec;
      end else begin
        mainValid <= 1'b0;
      end
    end else if (accept) begin
      if (mainValid) begin
        skidEntry <= dec;
        skidValid <= 1'b1;
      end else begin
        mainEntry <= dec;
        mainValid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      hazardCount <= '0;
    else if (hazard && !flush && hazardCount != CNT_MAX)
      hazardCount <= hazardCount + 1'b1;
  end

  assign bus.in_ready        = inReady;
  assign bus.out_valid       = mainValid;
  assign bus.out_instruction = mainEntry.instr;
  assign bus.out_rf_addr1    = mainEntry.addr1;
  assign bus.out_rf_addr2    = mainEntry.addr2;
  assign bus.out_dest        = mainEntry.dest;
  assign bus.out_writes_rf   = mainEntry.writesRf;
  assign bus.out_is_store    = mainEntry.isStore;
  assign bus.out_is_load     = mainEntry.isLoad;
  assign bus.hazard_count    = hazardCount;
endmodule
